// File: rtl/burst_wr_target_pkg.sv
// -----------------------------------------------------------------------------
// burst_wr_target_pkg
// Shared definitions for the burst write target:
//   - default data/address widths and expected burst length
//   - FSM state encoding (2 bits: IDLE=0, SETUP=1, DATA=2, HOLD=3)
//   - bit positions of the individual error causes folded into err
// -----------------------------------------------------------------------------
package burst_wr_target_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_AW  = 5;
    localparam int DEF_LEN = 20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        DATA  = ST_DATA,
        HOLD  = ST_HOLD
    } state_e;

    // Error-cause vector layout; err is the OR of all causes at close.
    localparam int LEN_ERR   = 0;
    localparam int PROTO_ERR = 1;
    localparam int ADDR_ERR  = 2;
    localparam int NUM_ERR   = 3;

endpackage

// File: rtl/burst_wr_target_mem.sv
// -----------------------------------------------------------------------------
// burst_tgt_mem
// 2**AW x DW register file, one write port and one registered read port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (read reg only)
//   wr_en/wr_addr/wr_data  write port, written on the rising edge
//   rd_en/rd_addr       read request; rd_data updates on the next edge
//   rd_data             registered read data, holds while rd_en=0
// A read and write to the same address in one cycle returns the old word.
// Storage is not reset.
// -----------------------------------------------------------------------------
module burst_tgt_mem
    import burst_wr_target_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/burst_wr_target.sv
// -----------------------------------------------------------------------------
// burst_wr_target
// Responder for the csn/we/addr burst-write interface. Stores every written
// word in a 2**AW-deep buffer, checks burst length (and protocol), and reports
// each closed burst with a one-cycle done pulse and a held err status.
//
// Optional feature macro: BURST_TGT_ADDR_CHECK_EN
//   defined   : an expected-address counter (0 at burst start, +1 per write)
//               flags any write whose addr differs; contributes to err.
//   undefined : no address checking.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   csn, we         chip select (active low) and write strobe
//   addr, din       write address / data, qualified by we while csn=0
//   rd_en, rd_addr  read request into the buffer
//   rd_data         registered read data (1-cycle latency)
//   busy            high while a burst is in progress
//   done            one-cycle pulse when a burst closes
//   err             status of the last closed burst, held until next done
//   word_cnt        words received in the last/current burst (saturating)
//
// Interface semantics: a word transfers on every rising edge where csn=0 and
// we=1 while a burst is open (SETUP/DATA/HOLD); there is no back-pressure.
// we with csn=1 is ignored. csn sampled high closes the burst (or aborts it
// from SETUP, without done).
// -----------------------------------------------------------------------------
module burst_wr_target
    import burst_wr_target_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int LEN = DEF_LEN
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          csn,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_cnt
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(2**AW);
    localparam logic [AW:0] LEN_W   = (AW+1)'(LEN);

    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [AW:0]  cnt_q, cnt_d;
    logic         ovf_q, ovf_d;     // more than 2**AW words seen
    logic         proto_q, proto_d; // we re-asserted after a HOLD gap
`ifdef BURST_TGT_ADDR_CHECK_EN
    logic [AW-1:0] exp_addr_q, exp_addr_d;
    logic          addr_err_q, addr_err_d;
`endif

    logic               wr_en;
    logic               close;
    logic [NUM_ERR-1:0] cause;

    always_comb begin
        cause            = '0;
        cause[LEN_ERR]   = (cnt_q != LEN_W) | ovf_q;
        cause[PROTO_ERR] = proto_q;
`ifdef BURST_TGT_ADDR_CHECK_EN
        cause[ADDR_ERR]  = addr_err_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        proto_d = proto_q;
`ifdef BURST_TGT_ADDR_CHECK_EN
        exp_addr_d = exp_addr_q;
        addr_err_d = addr_err_q;
`endif
        wr_en = 1'b0;
        close = 1'b0;

        case (state_q)
            IDLE: begin
                if (!csn) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    proto_d = 1'b0;
`ifdef BURST_TGT_ADDR_CHECK_EN
                    exp_addr_d = '0;
                    addr_err_d = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (csn) begin
                    // Abort: no done, err keeps the previous burst's status.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (we) begin
                    state_d = DATA;
                    wr_en   = 1'b1;
                end
            end
            DATA: begin
                if (csn) begin
                    close = 1'b1;
                end else if (we) begin
                    wr_en = 1'b1;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (csn) begin
                    close = 1'b1;
                end else if (we) begin
                    state_d = DATA;
                    wr_en   = 1'b1;
                    proto_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            // Saturate the visible count; remember the overflow separately so
            // a burst of exactly 2**AW + n words can never pass the length check.
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (AW+1)'(1);
            end
`ifdef BURST_TGT_ADDR_CHECK_EN
            if (addr != exp_addr_q) begin
                addr_err_d = 1'b1;
            end
            exp_addr_d = exp_addr_q + AW'(1);
`endif
        end

        if (close) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = |cause;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            proto_q <= 1'b0;
`ifdef BURST_TGT_ADDR_CHECK_EN
            exp_addr_q <= '0;
            addr_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            proto_q <= proto_d;
`ifdef BURST_TGT_ADDR_CHECK_EN
            exp_addr_q <= exp_addr_d;
            addr_err_q <= addr_err_d;
`endif
        end
    end

    burst_tgt_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_data (din),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_burst_wr_target.sv
// -----------------------------------------------------------------------------
// tb_burst_wr_target
// Bench for burst_wr_target. Inputs are driven and outputs sampled on the
// falling clock edge. Burst status ({err, word_cnt}) and read data are
// predicted by a small bench-side model and queued when stimulus is driven.
// -----------------------------------------------------------------------------
module tb_burst_wr_target;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int LEN   = 20;
    localparam int DEPTH = 2**AW;
    localparam int W     = AW + 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          csn     = 1'b1;
    logic          we      = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [DW-1:0] din     = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    always #5 clk = ~clk;

    burst_wr_target #(.DW(DW), .AW(AW), .LEN(LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .csn      (csn),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] rd_exp_q[$];

    // Reference model
    logic [DW-1:0] ref_mem [DEPTH];
    int m_cnt;
    int m_exp_addr;
    bit m_ovf, m_proto, m_aerr, m_in_data, m_held;
    bit m_last_err = 1'b0;

    logic [W-1:0]  got_st, exp_st;
    logic [DW-1:0] exp_rd;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic burst_start(input int n_setup);
        csn = 1'b0; we = 1'b0;
        m_cnt = 0; m_exp_addr = 0;
        m_ovf = 0; m_proto = 0; m_aerr = 0; m_in_data = 0; m_held = 0;
        repeat (n_setup) step();
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        csn = 1'b0; we = 1'b1; addr = a; din = d;
        if (m_held) m_proto = 1'b1;
        m_in_data = 1'b1;
        m_held = 1'b0;
        if (a != AW'(m_exp_addr)) m_aerr = 1'b1;
        m_exp_addr++;
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        else m_cnt++;
        ref_mem[a] = d;
        step();
        we = 1'b0;
    endtask

    task automatic hold_cycles(input int n);
        csn = 1'b0; we = 1'b0;
        if (m_in_data) m_held = 1'b1;
        repeat (n) step();
    endtask

    task automatic burst_end();
        logic e;
        csn = 1'b1; we = 1'b0;
        e = (m_cnt != LEN) || m_ovf || m_proto;
`ifdef BURST_TGT_ADDR_CHECK_EN
        e = e || m_aerr;
`endif
        m_last_err = e;
        exp_q.push_back({e, (AW+1)'(m_cnt)});
        step();
    endtask

    task automatic drive_nominal(input logic [DW-1:0] base);
        burst_start(4);
        for (int i = 0; i < LEN; i++) write_word(AW'(i), base + DW'(i));
        hold_cycles(4);
        burst_end();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; csn = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({busy, done, err, word_cnt, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b done=%b err=%b word_cnt=%0d rd_data=%h, expected all 0",
                     busy, done, err, word_cnt, rd_data);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_nominal();
        burst_start(1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_busy: busy=%b, expected 1", busy);
        end
        repeat (3) step();
        for (int i = 0; i < LEN; i++) write_word(AW'(i), 8'hA0 + DW'(i));
        hold_cycles(4);
        burst_end();
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL nominal_close: done=%b busy=%b err=%b word_cnt=%0d, expected done=1 busy=0 err=%b word_cnt=%0d",
                     done, busy, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_done_pulse: done=%b one cycle later, expected 0", done);
        end
        rd_en = 1'b1; rd_addr = 5; rd_exp_q.push_back(ref_mem[5]);
        step();
        rd_en = 1'b0; rd_addr = 9;
        exp_rd = rd_exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL nominal_read5: rd_data=%h, expected %h", rd_data, exp_rd);
        end
        step();
        n_checks++;
        if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL read_hold: rd_data=%h with rd_en=0, expected %h", rd_data, exp_rd);
        end
    endtask

    task automatic test_short();
        burst_start(2);
        for (int i = 0; i < 10; i++) write_word(AW'(i), 8'hB0 + DW'(i));
        burst_end();
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL short_close: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
    endtask

    task automatic test_abort();
        burst_start(3);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: busy=%b during setup, expected 1", busy);
        end
        csn = 1'b1;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== m_last_err) begin
            n_fail++;
            $display("FAIL abort_status: done=%b busy=%b err=%b, expected done=0 busy=0 err=%b",
                     done, busy, err, m_last_err);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b, expected 0", done);
        end
        // we with csn high must not touch the buffer or the status
        csn = 1'b1; we = 1'b1; addr = 5; din = 8'hFF;
        step();
        we = 1'b0;
        rd_en = 1'b1; rd_addr = 5; rd_exp_q.push_back(ref_mem[5]);
        step();
        rd_en = 1'b0;
        exp_rd = rd_exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_rd || busy !== 1'b0 || word_cnt !== (AW+1)'(m_cnt)) begin
            n_fail++;
            $display("FAIL ignored_write: rd_data=%h busy=%b word_cnt=%0d, expected rd_data=%h busy=0 word_cnt=%0d",
                     rd_data, busy, word_cnt, exp_rd, m_cnt);
        end
        drive_nominal(8'hA0);
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL err_cleared: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
    endtask

    task automatic test_addr_skip();
        burst_start(2);
        for (int i = 0; i < LEN; i++) write_word((i == 7) ? AW'(8) : AW'(i), 8'hA0 + DW'(i));
        hold_cycles(1);
        burst_end();
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL addr_skip: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
    endtask

    task automatic test_proto();
        burst_start(1);
        for (int i = 0; i < 10; i++) write_word(AW'(i), 8'hC0 + DW'(i));
        hold_cycles(2);
        for (int i = 10; i < LEN; i++) write_word(AW'(i), 8'hC0 + DW'(i));
        burst_end();
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL proto_gap: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
    endtask

    task automatic test_overflow();
        burst_start(1);
        for (int i = 0; i < DEPTH + 1; i++) write_word(AW'(i % DEPTH), 8'h10 + DW'(i));
        burst_end();
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL overflow_sat: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        burst_start(2);
        for (int i = 0; i < 12; i++) write_word(AW'(i), 8'hD0 + DW'(i));
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, word_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_data: busy=%b done=%b word_cnt=%0d, expected 0 0 0", busy, done, word_cnt);
        end
        csn = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        drive_nominal(8'hA0);
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL after_reset_burst: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        drive_nominal(8'hA0);
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        // csn falls in the done cycle
        burst_start(1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: done=%b busy=%b, expected done=0 busy=1", done, busy);
        end
        step();
        for (int i = 0; i < LEN; i++) begin
            if (i == 3) begin
                rd_en = 1'b1; rd_addr = 3; rd_exp_q.push_back(ref_mem[3]);
                write_word(AW'(i), 8'h50 + DW'(i));
                rd_en = 1'b0;
                exp_rd = rd_exp_q.pop_front();
                n_checks++;
                if (rd_data !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rw_same_addr: rd_data=%h, expected old data %h", rd_data, exp_rd);
                end
            end else begin
                write_word(AW'(i), 8'h50 + DW'(i));
            end
        end
        burst_end();
        got_st = {err, word_cnt}; exp_st = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1 || got_st !== exp_st) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b err=%b word_cnt=%0d, expected done=1 err=%b word_cnt=%0d",
                     done, err, word_cnt, exp_st[W-1], exp_st[AW:0]);
        end
        step();
        rd_en = 1'b1; rd_addr = 3; rd_exp_q.push_back(ref_mem[3]);
        step();
        rd_en = 1'b0;
        exp_rd = rd_exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL b2b_new_data: rd_data=%h, expected %h", rd_data, exp_rd);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_abort();
        test_addr_skip();
        test_proto();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before it");
        $fatal(1, "watchdog expired");
    end

endmodule
